// File: rtl/disp_share_arbiter.sv
// Two-source owner of the 3-digit seven-segment display: round-robin grant with hold time, blanking between owners.
// Grant and release act one cycle after the deciding edge; cathodes lag anodes/data by one cycle; no backpressure.
module disp_share_arbiter #(
    parameter int SCAN_DIV     = 32768,
    parameter int HOLD_CYCLES  = 50000000,
    parameter int BLANK_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [11:0] data0,
    input  logic        req1,
    input  logic [11:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [2:0]  anodes,
    output logic [7:0]  cathodes
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int BW = $clog2(BLANK_CYCLES + 1);

    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_CYCLES);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN0  = 2'd1;
    localparam logic [1:0] ST_OWN1  = 2'd2;
    localparam logic [1:0] ST_BLANK = 2'd3;

    logic [1:0]    state;
    logic [SW-1:0] scan_cnt;
    logic [HW-1:0] hold_cnt;
    logic [BW-1:0] blank_cnt;
    logic          last_owner;
    logic          pend;
    logic          pend_src;

    logic          owner_req;
    logic          other_req;
    logic [11:0]   owner_data;
    logic [3:0]    nib;
    logic          leave;

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        logic [7:0] s;
        s = 8'hFF;
        case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h98;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            4'hF: s = 8'h8E;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    always_comb begin
        owner_req  = (state == ST_OWN1) ? req1  : req0;
        other_req  = (state == ST_OWN1) ? req0  : req1;
        owner_data = (state == ST_OWN1) ? data1 : data0;
        case (anodes)
            3'b101:  nib = owner_data[7:4];
            3'b011:  nib = owner_data[11:8];
            default: nib = owner_data[3:0];
        endcase
        leave = !owner_req || (other_req && (hold_cnt >= HOLD_LAST));
    end

    // pend holds a decision taken on one edge so it is applied on the next,
    // giving the one-cycle latency for both grant and release.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            anodes     <= 3'b111;
            cathodes   <= 8'hFF;
            scan_cnt   <= '0;
            hold_cnt   <= '0;
            blank_cnt  <= '0;
            last_owner <= 1'b1;
            pend       <= 1'b0;
            pend_src   <= 1'b0;
        end else begin
            cathodes <= 8'hFF;
            case (state)
                ST_IDLE: begin
                    if (pend) begin
                        state      <= pend_src ? ST_OWN1 : ST_OWN0;
                        gnt0       <= !pend_src;
                        gnt1       <= pend_src;
                        last_owner <= pend_src;
                        anodes     <= 3'b110;
                        scan_cnt   <= '0;
                        hold_cnt   <= '0;
                        pend       <= 1'b0;
                    end else if (req0 || req1) begin
                        pend     <= 1'b1;
                        pend_src <= (req0 && req1) ? !last_owner : req1;
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                    if (pend) begin
                        state     <= ST_BLANK;
                        gnt0      <= 1'b0;
                        gnt1      <= 1'b0;
                        anodes    <= 3'b111;
                        blank_cnt <= '0;
                        pend      <= 1'b0;
                    end else begin
                        if (leave) begin
                            pend <= 1'b1;
                        end
                        cathodes <= hex_seg(nib);
                        if (scan_cnt == SCAN_LAST) begin
                            scan_cnt <= '0;
                            anodes   <= {anodes[0], anodes[2:1]};
                        end else begin
                            scan_cnt <= scan_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    if (blank_cnt == BLANK_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        blank_cnt <= blank_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Bench for disp_share_arbiter with small scan/hold/blank parameters.
module tb_disp_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [11:0] data0, data1;
    logic        gnt0, gnt1;
    logic [2:0]  anodes;
    logic [7:0]  cathodes;

    int tests = 0;
    int fails = 0;

    disp_share_arbiter #(
        .SCAN_DIV(4),
        .HOLD_CYCLES(8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req0(req0),
        .data0(data0),
        .req1(req1),
        .data1(data1),
        .gnt0(gnt0),
        .gnt1(gnt1),
        .anodes(anodes),
        .cathodes(cathodes)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] nib;
        logic [7:0] seg;
    } vec_t;

    typedef struct {
        logic [2:0] an;
        logic [7:0] cat;
    } exp_t;

    vec_t vecs[16];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_gnt0"}, gnt0, 0);
        check({name, "_gnt1"}, gnt1, 0);
        check({name, "_anodes"}, anodes, 3'b111);
        check({name, "_cathodes"}, cathodes, 8'hFF);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  an_seq [3];
        logic [11:0] dv;
        logic [3:0]  n;
        exp_t        e;
        int          cnt;
        int          grants_seen;
        logic        prev_g;

        vecs[0]  = '{4'h0, 8'hC0}; vecs[1]  = '{4'h1, 8'hF9};
        vecs[2]  = '{4'h2, 8'hA4}; vecs[3]  = '{4'h3, 8'hB0};
        vecs[4]  = '{4'h4, 8'h99}; vecs[5]  = '{4'h5, 8'h92};
        vecs[6]  = '{4'h6, 8'h82}; vecs[7]  = '{4'h7, 8'hF8};
        vecs[8]  = '{4'h8, 8'h80}; vecs[9]  = '{4'h9, 8'h98};
        vecs[10] = '{4'hA, 8'h88}; vecs[11] = '{4'hB, 8'h83};
        vecs[12] = '{4'hC, 8'hC6}; vecs[13] = '{4'hD, 8'hA1};
        vecs[14] = '{4'hE, 8'h86}; vecs[15] = '{4'hF, 8'h8E};
        an_seq[0] = 3'b110; an_seq[1] = 3'b011; an_seq[2] = 3'b101;

        data0 = 12'h000;
        data1 = 12'h000;
        do_reset();
        check_reset_vals("reset");

        // Single request and scan sequence through the scoreboard.
        dv    = 12'h1A3;
        data0 = dv;
        req0  = 1'b1;
        step();
        check("grant_latency_e1", gnt0, 0);
        step();
        check("grant_latency_e2", gnt0, 1);
        check("grant_gnt1", gnt1, 0);
        for (int k = 0; k < 16; k++) begin
            e.an = an_seq[(k / 4) % 3];
            if (k == 0) begin
                e.cat = 8'hFF;
            end else begin
                case ((k - 1) / 4 % 3)
                    0:       n = dv[3:0];
                    1:       n = dv[11:8];
                    default: n = dv[7:4];
                endcase
                e.cat = vecs[n].seg;
            end
            sb.push_back(e);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check("scan_anodes", anodes, e.an);
            check("scan_cathodes", cathodes, e.cat);
            step();
        end

        // Decode sweep over all nibbles on all three digits.
        for (int v = 0; v < 16; v++) begin
            data0 = {vecs[v].nib, vecs[v].nib, vecs[v].nib};
            step();
            for (int c = 0; c < 12; c++) begin
                check("decode", cathodes, vecs[v].seg);
                step();
            end
        end

        // Simultaneous requests: hold time, blanking and alternation.
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        step();
        step();
        for (int h = 0; h < 4; h++) begin
            check("handoff_owner", {gnt1, gnt0}, h[0] ? 2'b10 : 2'b01);
            cnt = 0;
            while ((gnt0 || gnt1) && cnt < 60) begin
                step();
                cnt++;
            end
            check("hold_len", cnt, 9);
            cnt = 0;
            while (!(gnt0 || gnt1) && cnt < 60) begin
                check("blank_anodes", anodes, 3'b111);
                check("blank_cathodes", cathodes, 8'hFF);
                step();
                cnt++;
            end
            check("blank_len", cnt, 4);
        end
        check("handoff_final", {gnt1, gnt0}, 2'b01);

        // Release by the sole owner; a request pulse during BLANK is dropped.
        do_reset();
        req1 = 1'b1;
        step();
        step();
        check("own1_grant", gnt1, 1);
        step();
        step();
        req1 = 1'b0;
        step();
        check("release_e1", gnt1, 1);
        step();
        check("release_gnt1", gnt1, 0);
        check("release_anodes", anodes, 3'b111);
        req0 = 1'b1;
        step();
        req0 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            check("blank_req_ignored", {gnt1, gnt0}, 2'b00);
        end
        req1 = 1'b1;
        step();
        step();
        check("regrant1", gnt1, 1);
        req1 = 1'b0;
        step();
        step();
        check("release2", gnt1, 0);
        req1 = 1'b1;
        cnt  = 0;
        while (!gnt1 && cnt < 60) begin
            step();
            cnt++;
        end
        check("held_req_through_blank", cnt, 4);

        // Reset in OWN1, then reset in BLANK after source 0 owned.
        step();
        reset = 1'b0;
        step();
        check_reset_vals("rst_own1");
        reset = 1'b1;
        req1  = 1'b0;
        req0  = 1'b1;
        step();
        check("post_rst_e1", gnt0, 0);
        step();
        check("post_rst_grant0", gnt0, 1);
        req0 = 1'b0;
        step();
        step();
        check("own0_released", gnt0, 0);
        reset = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        step();
        check_reset_vals("rst_blank");
        reset = 1'b1;
        step();
        step();
        check("post_rst_tie", {gnt1, gnt0}, 2'b01);

        // Random request traffic: mutual exclusion and anode legality.
        grants_seen = 0;
        prev_g      = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 15) == 0) req0 = !req0;
            if ($urandom_range(0, 15) == 0) req1 = !req1;
            if ($urandom_range(0, 31) == 0) data0 = 12'($urandom);
            if ($urandom_range(0, 31) == 0) data1 = 12'($urandom);
            step();
            check("rand_mutex", gnt0 & gnt1, 0);
            if (gnt0 || gnt1) begin
                check("rand_an_granted",
                      (anodes == 3'b110 || anodes == 3'b011 || anodes == 3'b101), 1);
                if (!prev_g) grants_seen++;
            end else begin
                check("rand_an_idle", anodes, 3'b111);
            end
            prev_g = gnt0 | gnt1;
        end
        check("rand_grants_seen", grants_seen > 20, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
